// File: rtl/booth_product_reg_if.sv
// rtl/booth_product_reg_if.sv - Booth product register control/ALU bundle; ovf under BOOTH_PRODUCT_REG_OVF_EN
interface booth_product_reg_if #(
    parameter int WIDTH = 32
);
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    logic                 start;
    logic [WIDTH-1:0]     multiplier;
    logic                 step_en;
    logic [WIDTH+1:0]     upper_in;
    logic [WIDTH+1:0]     upper_out;
    logic [2:0]           booth_bits;
    logic                 busy;
    logic                 done;
    logic [CW-1:0]        step_cnt;
    logic [2*WIDTH-1:0]   prod_out;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
    logic                 ovf;

    modport master (
        output start, multiplier, step_en, upper_in,
        input  upper_out, booth_bits, busy, done, step_cnt, prod_out, ovf
    );
    modport slave (
        input  start, multiplier, step_en, upper_in,
        output upper_out, booth_bits, busy, done, step_cnt, prod_out, ovf
    );
`else
    modport master (
        output start, multiplier, step_en, upper_in,
        input  upper_out, booth_bits, busy, done, step_cnt, prod_out
    );
    modport slave (
        input  start, multiplier, step_en, upper_in,
        output upper_out, booth_bits, busy, done, step_cnt, prod_out
    );
`endif
endinterface

// File: rtl/booth_product_reg.sv
// rtl/booth_product_reg.sv - radix-4 Booth product register with step sequencer; ovf under BOOTH_PRODUCT_REG_OVF_EN
module booth_product_reg #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                clr,
    booth_product_reg_if.slave  bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   upper_q, upper_d;
    logic [WIDTH-1:0]   lower_q, lower_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH+1:0]   step_upper;
    logic [WIDTH-1:0]   step_lower;
    logic               last_step;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
    logic               ovf_q, ovf_d;
    logic [WIDTH:0]     step_top;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            upper_q <= '0;
            lower_q <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Arithmetic shift right by 2 of {upper_in, lower, q_m1}; only the sign of upper_in is replicated
    always_comb begin
        step_upper = {{2{bus.upper_in[WIDTH+1]}}, bus.upper_in[WIDTH+1:2]};
        step_lower = {bus.upper_in[1:0], lower_q[WIDTH-1:2]};
        last_step  = (cnt_q == CW'(STEPS - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (bus.step_en && last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        upper_d = upper_q;
        lower_d = lower_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
        ovf_d    = ovf_q;
        step_top = {step_upper[WIDTH-1:0], step_lower[WIDTH-1]};
`endif
        if (state_q == S_IDLE && bus.start) begin
            upper_d = '0;
            lower_d = bus.multiplier;
            qm1_d   = 1'b0;
            cnt_d   = '0;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else if (state_q == S_RUN && bus.step_en) begin
            upper_d = step_upper;
            lower_d = step_lower;
            qm1_d   = lower_q[1];
            cnt_d   = cnt_q + 1'b1;
`ifdef BOOTH_PRODUCT_REG_OVF_EN
            // The product must fit WIDTH signed bits: top WIDTH+1 bits all equal
            if (last_step) ovf_d = !((&step_top) || !(|step_top));
`endif
        end
    end

    always_comb begin
        bus.busy       = (state_q == S_RUN);
        bus.done       = (state_q == S_DONE);
        bus.upper_out  = upper_q;
        bus.booth_bits = {lower_q[1:0], qm1_q};
        bus.step_cnt   = cnt_q;
        bus.prod_out   = {upper_q[WIDTH-1:0], lower_q};
`ifdef BOOTH_PRODUCT_REG_OVF_EN
        bus.ovf        = ovf_q;
`endif
    end
endmodule

// File: tb/tb_booth_product_reg.sv
// tb/tb_booth_product_reg.sv - directed bench with ALU model and product scoreboard; ovf checks under BOOTH_PRODUCT_REG_OVF_EN
module tb_booth_product_reg;
    localparam int W = 32;

    typedef struct packed {
        logic [63:0] prod;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic signed [W-1:0] mcand;

    booth_product_reg_if #(.WIDTH(W)) bus ();
    booth_product_reg #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] pp(input logic [2:0] b, input logic signed [W-1:0] m);
        logic signed [W+1:0] m34;
        m34 = m;
        case (b)
            3'b001, 3'b010: return m34;
            3'b011:         return m34 <<< 1;
            3'b100:         return -(m34 <<< 1);
            3'b101, 3'b110: return -m34;
            default:        return '0;
        endcase
    endfunction

    task automatic drive_step();
        bus.step_en  = 1'b1;
        bus.upper_in = bus.upper_out + pp(bus.booth_bits, mcand);
        @(negedge clk);
    endtask

    task automatic begin_op(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp);
        exp_t   e;
        longint p;
        p      = longint'(mc) * longint'(mp);
        e.prod = p;
        e.ovf  = !((&e.prod[63:31]) || !(|e.prod[63:31]));
        sb_q.push_back(e);
        mcand          = mc;
        bus.start      = 1'b1;
        bus.multiplier = mp;
        bus.step_en    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("cnt_after_start", 64'(bus.step_cnt), 64'd0);
`ifdef BOOTH_PRODUCT_REG_OVF_EN
        check("ovf_cleared_on_start", 64'(bus.ovf), 64'd0);
`endif
    endtask

    task automatic finish_op(input string tag);
        exp_t e;
        bus.step_en = 1'b0;
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
        if (bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_prod"}, bus.prod_out, e.prod);
`ifdef BOOTH_PRODUCT_REG_OVF_EN
                check({tag, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
`endif
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse_ends"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic signed [W-1:0] mc,
                          input logic signed [W-1:0] mp, input int stall_at, input int stall_len);
        logic [W+1:0] held_upper;
        begin_op(mc, mp);
        for (int k = 0; k < W / 2; k++) begin
            if (k == stall_at) begin
                held_upper = bus.upper_out;
                for (int s = 0; s < stall_len; s++) begin
                    bus.step_en = 1'b0;
                    bus.start   = 1'b1;
                    @(negedge clk);
                    check({tag, "_stall_cnt"}, 64'(bus.step_cnt), 64'(k));
                    check({tag, "_stall_busy"}, 64'(bus.busy), 64'd1);
                end
                bus.start = 1'b0;
                check({tag, "_stall_held"}, 64'(bus.upper_out), 64'(held_upper));
            end
            drive_step();
        end
        finish_op(tag);
    endtask

    initial begin
        logic [63:0] last_prod;
        bus.start      = 1'b1;
        bus.multiplier = 32'd123;
        bus.step_en    = 1'b0;
        bus.upper_in   = '0;
        mcand          = '0;
        clr            = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_prod", bus.prod_out, 64'd0);
        check("rst_cnt", 64'(bus.step_cnt), 64'd0);
        bus.start = 1'b0;
        clr       = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 64'(bus.busy), 64'd0);

        run_op("p6x7", 32'sd6, 32'sd7, -1, 0);
        check("p6x7_const", bus.prod_out, 64'h0000_0000_0000_002A);

        // step_en in IDLE must not disturb the held product
        last_prod    = bus.prod_out;
        bus.step_en  = 1'b1;
        bus.upper_in = 34'h3_DEAD_BEEF;
        @(negedge clk);
        bus.step_en = 1'b0;
        check("idle_step_ignored", bus.prod_out, last_prod);
        check("idle_step_busy", 64'(bus.busy), 64'd0);

        run_op("pm3x5", -32'sd3, 32'sd5, -1, 0);
        check("pm3x5_const", bus.prod_out, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("pminxmin", 32'h8000_0000, 32'h8000_0000, -1, 0);
        check("pminxmin_const", bus.prod_out, 64'h4000_0000_0000_0000);
        run_op("stall", 32'sd1234567, -32'sd7654321, 4, 5);
        run_op("rnd", $signed($urandom()), $signed($urandom()), -1, 0);

        // Reset mid-operation: no done pulse, state cleared
        mcand          = 32'sd6;
        bus.start      = 1'b1;
        bus.multiplier = 32'sd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) drive_step();
        check("abort_cnt_before", 64'(bus.step_cnt), 64'd8);
        clr = 1'b0;
        drive_step();
        bus.step_en = 1'b0;
        clr         = 1'b1;
        check("abort_prod", bus.prod_out, 64'd0);
        check("abort_cnt", 64'(bus.step_cnt), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        for (int s = 0; s < 3; s++) begin
            check("abort_no_done", 64'(bus.done), 64'd0);
            @(negedge clk);
        end
        run_op("after_abort", -32'sd1000, 32'sd999, -1, 0);

`ifdef BOOTH_PRODUCT_REG_OVF_EN
        run_op("ovf_big", 32'h0001_0000, 32'h0001_0000, -1, 0);
        check("ovf_big_set", 64'(bus.ovf), 64'd1);
        run_op("ovf_small", 32'sd7, 32'sd6, -1, 0);
        check("ovf_small_clr", 64'(bus.ovf), 64'd0);
`endif
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
